// File: rtl/qos_pkg.sv
// qos_pkg: shared constants and types for the QoS egress path
package qos_pkg;
  localparam int DATA_W = 12;
  localparam int CNT_W = 5;
  localparam int NUM_Q = 4;
  localparam int OBUF_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} egress_state_t;
  typedef logic [1:0] class_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: grants the first request at or after ptr, searching upward and wrapping 3->0
module rr_arbiter4 (
  input  logic [3:0] request,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] grant_idx
);
  logic [3:0] rot;
  logic [1:0] off;
  assign rot = ptr == 2'd0 ? request :
               ptr == 2'd1 ? {request[0], request[3:1]} :
               ptr == 2'd2 ? {request[1:0], request[3:2]} :
                             {request[2:0], request[3]};
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign grant_idx = ptr + off;
  assign grant = |request ? 4'b0001 << grant_idx : 4'b0000;
endmodule

// File: rtl/qos_egress_reader.sv
// qos_egress_reader: round-robin reader of four BP FIFOs into a 2-entry tagged output buffer with per-class counters
module qos_egress_reader
  import qos_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty0,
  input  logic              fifo_empty1,
  input  logic              fifo_empty2,
  input  logic              fifo_empty3,
  input  logic [DATA_W-1:0] fifo_dataout0,
  input  logic [DATA_W-1:0] fifo_dataout1,
  input  logic [DATA_W-1:0] fifo_dataout2,
  input  logic [DATA_W-1:0] fifo_dataout3,
  output logic              popBP0,
  output logic              popBP1,
  output logic              popBP2,
  output logic              popBP3,
  output logic [DATA_W-1:0] out_data,
  output class_t            out_class,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              idle_out,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic              valid,
  output logic [CNT_W-1:0]  data
);
  egress_state_t state, state_nx;
  logic [3:0] nonempty, gnt;
  class_t rr_ptr, gnt_idx, infl_cls;
  logic [1:0] occ;
  logic infl, pop, rd, rd_ptr, wr_ptr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] buf_data [OBUF_DEPTH];
  class_t buf_cls [OBUF_DEPTH];
  logic [CNT_W-1:0] cnt [NUM_Q];

  assign nonempty = ~{fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0};

  rr_arbiter4 u_arb (
    .request  (nonempty),
    .ptr      (rr_ptr),
    .grant    (gnt),
    .grant_idx(gnt_idx)
  );

  assign pop = !reset && state == ACTIVE && enable && |nonempty &&
               (infl ? occ == 2'd0 : occ != 2'(OBUF_DEPTH));
  assign {popBP3, popBP2, popBP1, popBP0} = pop ? gnt : 4'b0000;
  assign din = infl_cls == 2'd0 ? fifo_dataout0 :
               infl_cls == 2'd1 ? fifo_dataout1 :
               infl_cls == 2'd2 ? fifo_dataout2 : fifo_dataout3;
  assign out_valid = occ != 2'd0;
  assign rd = out_valid && out_ready;
  assign out_data = buf_data[rd_ptr];
  assign out_class = buf_cls[rd_ptr];
  assign idle_out = state == IDLE;

  always_comb begin
    state_nx = state == IDLE   ? (enable && |nonempty ? ACTIVE : IDLE) :
               state == ACTIVE ? (!enable ? DRAIN : (!(|nonempty) && !infl && occ == 2'd0) ? IDLE : ACTIVE) :
                                 (enable && occ != 2'd0) ? ACTIVE : (!infl && occ == 2'd0) ? IDLE : DRAIN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      infl <= 1'b0;
      infl_cls <= '0;
      occ <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      valid <= 1'b0;
      data <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_cls[i] <= '0;
      end
      for (int i = 0; i < NUM_Q; i++) cnt[i] <= '0;
    end else begin
      state <= state_nx;
      infl <= pop;
      if (pop) begin
        rr_ptr <= gnt_idx + 2'd1;
        infl_cls <= gnt_idx;
      end
      if (infl) begin
        buf_data[wr_ptr] <= din;
        buf_cls[wr_ptr] <= infl_cls;
        wr_ptr <= ~wr_ptr;
        cnt[infl_cls] <= cnt[infl_cls] + 1'b1;
      end
      if (rd) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, infl} - {1'b0, rd};
      valid <= req;
      data <= (req && !idx[2]) ? cnt[idx[1:0]] : '0;
    end
  end
endmodule

// File: doc/qos_egress_reader.md
Name: qos_egress_reader

Overview:
Egress-side consumer for the four back-pressure FIFOs of the QoS path. It arbitrates round-robin among the non-empty FIFOs and issues popBP0..3. It captures the returned 12-bit words into a 2-entry output buffer and presents them downstream with a valid/ready handshake, tagged with their class. It also keeps per-class word counters that are readable through the same req/idx -> valid/data counter interface used elsewhere in the QoS path.

Parameters:
DATA_W, 12, FIFO word width
CNT_W, 5, per-class counter width (wraps)
OBUF_DEPTH, 2, output buffer entries (fixed; not a generic depth)

Ports:
clk  input  1  single clock, all logic posedge
reset  input  1  synchronous, active-high
enable  input  1  permits new pops; deassertion drains in-flight data
fifo_empty0..3  input  1 each  empty flag of BP FIFO 0..3
fifo_dataout0..3  input  DATA_W each  BP FIFO read data, valid the cycle after its pop
popBP0..3  output  1 each  pop strobe to BP FIFO 0..3; at most one high per cycle
out_data  output  DATA_W  head word of output buffer
out_class  output  2  source FIFO index of out_data
out_valid  output  1  output buffer non-empty
out_ready  input  1  downstream accepts when out_valid & out_ready
idle_out  output  1  FSM in IDLE
req  input  1  counter read request
idx  input  3  counter index
valid  output  1  counter read response strobe
data  output  CNT_W  counter read value

Behaviour:
- Reset (sync, high): all outputs are 0, except idle_out = 1. FSM goes to IDLE. Round-robin pointer = 0. Buffer, in-flight flag and all counters are cleared. Reset mid-operation discards in-flight and buffered words; no pop is issued in the reset cycle.
- Pop eligibility:
  - The FSM is in ACTIVE and enable = 1.
  - At least one fifo_emptyN = 0.
  - Buffer occupancy + in-flight (0/1) + 0 < OBUF_DEPTH, i.e. one free slot is guaranteed for the returning word. A slot freed by an out_ready pop in the same cycle does not count.
- Arbitration: pick the first non-empty queue starting at rr_ptr, searching ascending and wrapping 3->0. After a pop, rr_ptr = granted+1 (mod 4). With no pop, rr_ptr holds.
- Pop-to-data latency is 1 cycle. The cycle after popBPn, fifo_dataoutn is written to the buffer tail with class n. out_valid rises the following cycle (no bypass), so pop -> out_valid = 2 cycles.
- Buffer: 2-entry FIFO. Simultaneous write and read are legal at any occupancy ≤ 2. out_data/out_class are stable while out_valid & !out_ready.
- Counters: cnt[n] increments when class-n word is written into the buffer. 31 + 1 wraps to 0.
- Counter read: req = 1 in cycle T gives valid = 1 and data = cnt[idx] in T+1.
  - idx ≥ 4: valid = 1, data = 0.
  - A read coinciding with an increment of the same counter returns the pre-increment value.
  - req held high gives a response every cycle.
- FSM states IDLE, ACTIVE, DRAIN:
  - IDLE -> ACTIVE: enable & any non-empty.
  - ACTIVE -> DRAIN: !enable. No further pops.
  - ACTIVE -> IDLE: all empty & no in-flight & buffer empty.
  - DRAIN -> IDLE: no in-flight & buffer empty.
  - DRAIN -> ACTIVE: enable reasserts while a buffer entry is still pending.
- A FIFO whose empty flag is high is never popped. Behaviour with corrupted flags is undefined.

Decomposition:
- Shared package qos_pkg:
  - DATA_W, CNT_W, NUM_Q = 4
  - egress FSM state enum {IDLE, ACTIVE, DRAIN}
  - class index typedef (2 bits)
- One sub-module, rr_arbiter4: inputs request[3:0] and ptr[1:0]; outputs grant one-hot and grant_idx. Combinational, reusable for the ingress demux side.

Test Plan:
- Reset then words 0x37D, 0xF04 in FIFO0 and 0xE95 in FIFO2, enable = 1, out_ready = 1 -> pops in order BP0, BP2, BP0. Output 0x37D/c0, 0xE95/c2, 0xF04/c0, each 2 cycles after its pop. Afterwards idle_out = 1.
- All four FIFOs hold one word (0xAAE, 0xB5A, 0x111, 0x222), out_ready = 0 -> exactly 2 pops (BP0, BP1), then popBP all 0 while out_valid holds 0xAAE. Raise out_ready -> BP2 and BP3 follow. Total outputs = 4.
- Deassert enable one cycle after a pop -> no new pops, FSM DRAIN, the in-flight word is still delivered, then idle_out = 1.
- Push 33 words into FIFO1 -> reading req = 1, idx = 1 returns valid = 1, data = 1 (wrap). idx = 5 returns valid = 1, data = 0.
- Read idx = 0 in the same cycle cnt[0] goes 3 -> 4 -> data = 3. The next read returns 4.
- Assert reset with 2 buffered words and 1 in flight -> the next cycle shows out_valid = 0, all counters 0, idle_out = 1, no pop.
